// File: rtl/ramp_sequencer_pkg.sv
// ramp_sequencer_pkg: shared state encoding for the ramp sequencer
package ramp_sequencer_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RAMP  = 2'd1,
        DWELL = 2'd2
    } state_t;
endpackage

// File: rtl/ramp_sequencer_tick_prescaler.sv
// ramp_sequencer_tick_prescaler: counts 0..divider and ticks on the last count while enabled
module ramp_sequencer_tick_prescaler #(
    parameter int divider_width = 8
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     clear,
    input  logic                     enable,
    input  logic [divider_width-1:0] divider,
    output logic                     tick
);
    logic [divider_width-1:0] count;

    assign tick = enable && (count == divider);

    // restart on clear or after each tick, otherwise advance while enabled
    always_ff @(posedge clock) begin
        if (!reset_n) count <= '0;
        else if (clear || tick) count <= '0;
        else if (enable) count <= count + divider_width'(1);
    end
endmodule

// File: rtl/ramp_sequencer.sv
// ramp_sequencer: slews output_value toward handshaked setpoints, dwells, then reports done
module ramp_sequencer
    import ramp_sequencer_pkg::*;
#(
    parameter int                  bitwidth      = 8,
    parameter int                  dwell_width   = 16,
    parameter int                  divider_width = 8,
    parameter logic [bitwidth-1:0] initial_value = '0
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [bitwidth-1:0]      setpoint_value,
    input  logic [dwell_width-1:0]   setpoint_dwell,
    input  logic [divider_width-1:0] step_divider,
    input  logic                     setpoint_valid,
    output logic                     setpoint_ready,
    input  logic                     abort,
    output logic [bitwidth-1:0]      output_value,
    output logic                     busy,
    output logic                     arrived,
    output logic                     done
);
    state_t                   state, state_next;
    logic [bitwidth-1:0]      target, target_next, value_next;
    logic [dwell_width-1:0]   dwell, dwell_next, dwell_cnt, dwell_cnt_next;
    logic [divider_width-1:0] divider, divider_next;
    logic                     arrived_next, done_next, clear, tick;

    assign setpoint_ready = (state == IDLE) && !abort;
    assign busy           = (state != IDLE);

    ramp_sequencer_tick_prescaler #(.divider_width(divider_width)) u_prescaler (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (clear),
        .enable  (state == RAMP),
        .divider (divider),
        .tick    (tick)
    );

    // register state, latched command, counters and the pulse outputs
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state        <= IDLE;
            output_value <= initial_value;
            target       <= '0;
            dwell        <= '0;
            divider      <= '0;
            dwell_cnt    <= '0;
            arrived      <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_next;
            output_value <= value_next;
            target       <= target_next;
            dwell        <= dwell_next;
            divider      <= divider_next;
            dwell_cnt    <= dwell_cnt_next;
            arrived      <= arrived_next;
            done         <= done_next;
        end
    end

    // next state: abort wins and freezes the output; arrival beats stepping in RAMP
    always_comb begin
        state_next     = state;
        value_next     = output_value;
        target_next    = target;
        dwell_next     = dwell;
        divider_next   = divider;
        dwell_cnt_next = dwell_cnt;
        arrived_next   = 1'b0;
        done_next      = 1'b0;
        clear          = 1'b0;
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (setpoint_valid) begin
                        target_next  = setpoint_value;
                        dwell_next   = setpoint_dwell;
                        divider_next = step_divider;
                        clear        = 1'b1;
                        state_next   = RAMP;
                    end
                end
                RAMP: begin
                    if (output_value == target) begin
                        arrived_next   = 1'b1;
                        dwell_cnt_next = dwell;
                        state_next     = DWELL;
                    end else if (tick) begin
                        value_next = (output_value < target) ? output_value + bitwidth'(1)
                                                             : output_value - bitwidth'(1);
                    end
                end
                DWELL: begin
                    if (dwell_cnt == '0) begin
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        dwell_cnt_next = dwell_cnt - dwell_width'(1);
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end
endmodule
